core_apb_mst: RTL and testbench

APB initiator that turns single-outstanding valid/ready requests from the core's uncached MMIO path into APB3/APB4 SETUP/ACCESS transfers on an `apb_intf` master port. Its output feeds the core-local APB splitter that fans out to cfgreg, dbgmon and intc. It also returns the read data and error status to the requester over a valid/ready response channel. One transfer is in flight at a time.

---
 rtl/core_apb_mst_if.sv | 24 ++
 rtl/core_apb_mst.sv | 138 +++++++++++++
 tb/tb_core_apb_mst.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_apb_mst_if.sv
// APB3/APB4 bus interface shared by core_apb_mst and the core-local APB splitter.
// The master modport drives the request side; the slave modport returns data and status.
interface apb_intf;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/core_apb_mst.sv
// APB initiator for the uncached MMIO path. It handles one transfer at a time through IDLE/SETUP/ACCESS/RESP.
// Optional ACCESS timeout abort: define CORE_APB_MST_TIMEOUT_EN.
module core_apb_mst #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [3:0]  req_strb,
  input  logic [2:0]  req_prot,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  apb_intf.master     m_apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e      state_q;
  logic        psel_q;
  logic        penable_q;
  logic [31:0] paddr_q;
  logic        pwrite_q;
  logic [3:0]  pstrb_q;
  logic [2:0]  pprot_q;
  logic [31:0] pwdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        timeout_hit;

`ifdef CORE_APB_MST_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !m_apb.pready) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // A pready in the same cycle as the limit wins, so the abort is qualified by !pready.
  assign timeout_hit = (state_q == ACCESS) && !m_apb.pready &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            paddr_q  <= req_addr;
            pwrite_q <= req_write;
            pstrb_q  <= req_write ? req_strb : 4'h0;
            pprot_q  <= req_prot;
            pwdata_q <= req_wdata;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (m_apb.pready) begin
            rsp_rdata_q <= pwrite_q ? 32'h0 : m_apb.prdata;
            rsp_err_q   <= m_apb.pslverr;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q <= 32'hdeadbeef;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

  assign m_apb.psel    = psel_q;
  assign m_apb.penable = penable_q;
  assign m_apb.paddr   = paddr_q;
  assign m_apb.pwrite  = pwrite_q;
  assign m_apb.pstrb   = pstrb_q;
  assign m_apb.pprot   = pprot_q;
  assign m_apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_core_apb_mst.sv
// Self-checking bench for core_apb_mst. It applies directed table vectors and random transfers, checks them
// against a transaction-level model, and finishes with hand sequences for reset and timeout.
module tb_core_apb_mst;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  apb_intf apb ();

  core_apb_mst #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_apb     (apb)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          bp;
    bit          holdValid;
    logic [31:0] expRdata;
    logic        expErr;
    int          expAccesses;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    apb.pready = 1'b0;
    step();
    step();
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  // Transaction-level expectation: a slave that answers after v.waits wait states, or never if the limit comes first.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
`ifdef CORE_APB_MST_TIMEOUT_EN
    if (v.waits >= TO) begin
      r.expAccesses = TO;
      r.expErr      = 1'b1;
      r.expRdata    = 32'hdeadbeef;
      return r;
    end
`endif
    r.expAccesses = v.waits + 1;
    r.expErr      = v.slverr;
    r.expRdata    = v.write ? 32'h0 : v.prdata;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v, input bit expectResp, input int budget);
    logic [3:0] expStrb;
    int accesses;
    int lat;
    bit done;
    expStrb  = v.write ? v.strb : 4'h0;
    accesses = 0;
    done     = 1'b0;
    checkOutput({v.name, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.write;
    req_strb  = v.strb;
    req_prot  = v.prot;
    req_wdata = v.wdata;
    rsp_ready = 1'b0;
    step();
    lat = 1;
    if (v.holdValid) req_addr = v.addr ^ 32'hffff0000;
    else req_valid = 1'b0;
    checkOutput({v.name, ".setup_psel"}, 32'(apb.psel), 32'd1);
    checkOutput({v.name, ".setup_penable"}, 32'(apb.penable), 32'd0);
    checkOutput({v.name, ".setup_pstrb"}, 32'(apb.pstrb), 32'(expStrb));
    checkOutput({v.name, ".setup_paddr"}, apb.paddr, v.addr);
    checkOutput({v.name, ".setup_pwdata"}, apb.pwdata, v.wdata);
    checkOutput({v.name, ".setup_pprot"}, 32'(apb.pprot), 32'(v.prot));
    checkOutput({v.name, ".setup_pwrite"}, 32'(apb.pwrite), 32'(v.write));
    checkOutput({v.name, ".setup_req_ready"}, 32'(req_ready), 32'd0);
    step();
    lat = 2;
    while (!done && lat < budget) begin
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        if (apb.psel && apb.penable) accesses++;
        checkOutput({v.name, ".access_stable"},
                    32'(apb.paddr == v.addr && apb.pstrb == expStrb && apb.pwdata == v.wdata), 32'd1);
        if (accesses == v.waits + 1) begin
          apb.pready  = 1'b1;
          apb.prdata  = v.prdata;
          apb.pslverr = v.slverr;
        end else begin
          apb.pready  = 1'b0;
          apb.prdata  = $urandom;
          apb.pslverr = 1'($urandom);
        end
        step();
        lat++;
      end
    end
    apb.pready = 1'b0;
    if (!expectResp) begin
      checkOutput({v.name, ".no_response"}, 32'(done), 32'd0);
      return;
    end
    checkOutput({v.name, ".rsp_arrived"}, 32'(done), 32'd1);
    if (!done) begin
      doReset();
      return;
    end
    checkOutput({v.name, ".latency"}, 32'(lat), 32'(v.expAccesses + 2));
    checkOutput({v.name, ".accesses"}, 32'(accesses), 32'(v.expAccesses));
    checkOutput({v.name, ".rdata"}, rsp_rdata, v.expRdata);
    checkOutput({v.name, ".err"}, 32'(rsp_err), 32'(v.expErr));
    checkOutput({v.name, ".resp_psel"}, 32'({apb.psel, apb.penable}), 32'd0);
    for (int i = 0; i < v.bp; i++) begin
      step();
      checkOutput({v.name, ".bp_hold"},
                  32'(rsp_valid && rsp_rdata == v.expRdata && rsp_err == v.expErr), 32'd1);
      checkOutput({v.name, ".bp_idle_bus"}, 32'({req_ready, apb.psel}), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput({v.name, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    checkOutput({v.name, ".req_ready_after"}, 32'(req_ready), 32'd1);
    checkOutput({v.name, ".not_reaccepted"}, 32'(apb.psel), 32'd0);
    req_valid = 1'b0;
  endtask

  vec_t tbl[4];
  vec_t rv;

  initial begin
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;

    tbl[0] = '{name:"zw_read", write:1'b0, addr:32'h0000_1004, wdata:32'h1111_2222, strb:4'hf,
               prot:3'b010, waits:0, prdata:32'h1234_5678, slverr:1'b0, bp:0, holdValid:1'b0,
               expRdata:32'h1234_5678, expErr:1'b0, expAccesses:1};
    tbl[1] = '{name:"wr_3ws", write:1'b1, addr:32'h0000_2000, wdata:32'hCAFE_F00D, strb:4'h3,
               prot:3'b001, waits:3, prdata:32'h55aa_55aa, slverr:1'b0, bp:0, holdValid:1'b0,
               expRdata:32'h0, expErr:1'b0, expAccesses:4};
    tbl[2] = '{name:"slverr", write:1'b0, addr:32'h0000_3000, wdata:32'h0, strb:4'h0,
               prot:3'b000, waits:1, prdata:32'ha5a5_a5a5, slverr:1'b1, bp:2, holdValid:1'b1,
               expRdata:32'ha5a5_a5a5, expErr:1'b1, expAccesses:2};
    tbl[3] = '{name:"backpr", write:1'b0, addr:32'h0000_4008, wdata:32'h0, strb:4'h5,
               prot:3'b111, waits:2, prdata:32'h0bad_f00d, slverr:1'b0, bp:5, holdValid:1'b0,
               expRdata:32'h0bad_f00d, expErr:1'b0, expAccesses:3};

    doReset();
    checkOutput("reset.req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset.psel_penable", 32'({apb.psel, apb.penable}), 32'd0);
    checkOutput("reset.rsp_valid_err", 32'({rsp_valid, rsp_err}), 32'd0);
    checkOutput("reset.paddr", apb.paddr, 32'd0);
    checkOutput("reset.pwdata", apb.pwdata, 32'd0);
    checkOutput("reset.rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset.ctrl", 32'({apb.pstrb, apb.pprot, apb.pwrite}), 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(tbl[i], 1'b1, 200);

    for (int i = 0; i < 20; i++) begin
      rv.name      = "rand";
      rv.write     = 1'($urandom);
      rv.addr      = $urandom;
      rv.wdata     = $urandom;
      rv.strb      = 4'($urandom);
      rv.prot      = 3'($urandom);
      rv.waits     = int'($urandom_range(0, 3));
      rv.prdata    = $urandom;
      rv.slverr    = 1'($urandom);
      rv.bp        = int'($urandom_range(0, 2));
      rv.holdValid = 1'b0;
      applyStimulus(model(rv), 1'b1, 200);
    end

    // Reset in the middle of a wait state must drop the bus asynchronously.
    req_valid = 1'b1;
    req_addr  = 32'h0000_5000;
    req_write = 1'b0;
    step();
    req_valid = 1'b0;
    apb.pready = 1'b0;
    step();
    step();
    checkOutput("midrst.before_penable", 32'(apb.penable), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midrst.psel", 32'(apb.psel), 32'd0);
    checkOutput("midrst.penable", 32'(apb.penable), 32'd0);
    checkOutput("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    checkOutput("midrst.req_ready", 32'(req_ready), 32'd1);
    step();
    checkOutput("midrst.no_rsp", 32'({rsp_valid, apb.psel}), 32'd0);

    rv = '{name:"hang", write:1'b1, addr:32'h0000_6000, wdata:32'h7777_8888, strb:4'hc,
           prot:3'b000, waits:1000, prdata:32'h0, slverr:1'b0, bp:1, holdValid:1'b0,
           expRdata:32'h0, expErr:1'b0, expAccesses:0};
`ifdef CORE_APB_MST_TIMEOUT_EN
    applyStimulus(model(rv), 1'b1, 200);
`else
    applyStimulus(rv, 1'b0, 102);
    doReset();
    checkOutput("hang.recovered", 32'(req_ready), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
